// File: rtl/seq_copy_pkg.sv
// rtl/seq_copy_pkg.sv - shared states, op codes and timing constants for the copy engine
package seq_copy_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    XFER   = 3'd2,
    COMMIT = 3'd3,
    FIN    = 3'd4
  } state_t;

  // Code 3 is reserved and decodes as a plain copy.
  typedef enum logic [1:0] {
    OP_COPY = 2'd0,
    OP_ADD  = 2'd1,
    OP_SCAN = 2'd2
  } op_t;

  localparam int ELEM_CYCLES = 4;

endpackage

// File: rtl/seq_copy_alu.sv
// rtl/seq_copy_alu.sv - per-element transform; all arithmetic wraps at WIDTH bits
module seq_copy_alu
  import seq_copy_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] bias_i,
  input  logic [WIDTH-1:0] sum_i,
  output logic [WIDTH-1:0] c_next_o,
  output logic [WIDTH-1:0] sum_next_o
);

  always_comb begin
    c_next_o   = b_i;
    sum_next_o = sum_i;
    case (op_i)
      OP_ADD: c_next_o = b_i + bias_i;
      OP_SCAN: begin
        c_next_o   = sum_i + b_i;
        sum_next_o = sum_i + b_i;
      end
      default: c_next_o = b_i;
    endcase
  end

endmodule

// File: rtl/std_reg.sv
// rtl/std_reg.sv - holding register with write enable and sync active-low clear
module std_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_i,
  input  logic             write_en_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] val_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      val_q <= '0;
    end else if (write_en_i) begin
      val_q <= in_i;
    end
  end

  assign out_o = val_q;

endmodule

// File: rtl/seq_copy_engine.sv
// rtl/seq_copy_engine.sv - go/done sequencer streaming len elements memory-to-memory via b and c
module seq_copy_engine
  import seq_copy_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE:0]   len,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    bias,
  output logic                done,
  output logic [IDX_SIZE-1:0] in_addr0,
  output logic                in_clk,
  input  logic [WIDTH-1:0]    in_read_data,
  output logic [IDX_SIZE-1:0] out_addr0,
  output logic [WIDTH-1:0]    out_write_data,
  output logic                out_write_en,
  output logic                out_clk,
  input  logic                out_done
);

  localparam logic [IDX_SIZE:0] SIZE_L = (IDX_SIZE + 1)'(SIZE);

  state_t              state_q, state_d;
  logic [IDX_SIZE-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic [IDX_SIZE:0]   len_q, len_d;
  logic [1:0]          op_q, op_d;
  logic [WIDTH-1:0]    bias_q, bias_d;

  logic [WIDTH-1:0]    b_val, c_val, c_next, sum_next;
  logic                last_elem;

  std_reg #(.WIDTH(WIDTH)) u_b (
    .clk        (clk),
    .reset      (reset),
    .in_i       (in_read_data),
    .write_en_i (state_q == LOAD),
    .out_o      (b_val)
  );

  std_reg #(.WIDTH(WIDTH)) u_c (
    .clk        (clk),
    .reset      (reset),
    .in_i       (c_next),
    .write_en_i (state_q == XFER),
    .out_o      (c_val)
  );

  seq_copy_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i       (op_q),
    .b_i        (b_val),
    .bias_i     (bias_q),
    .sum_i      (sum_q),
    .c_next_o   (c_next),
    .sum_next_o (sum_next)
  );

  assign last_elem = ({1'b0, idx_q} == (len_q - (IDX_SIZE + 1)'(1)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    len_d   = len_q;
    op_d    = op_q;
    bias_d  = bias_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          len_d   = (len > SIZE_L) ? SIZE_L : len;
          op_d    = op;
          bias_d  = bias;
          idx_d   = '0;
          sum_d   = '0;
          state_d = (len == '0) ? FIN : LOAD;
        end
      end
      LOAD: state_d = XFER;
      XFER: begin
        sum_d   = sum_next;
        state_d = COMMIT;
      end
      // Write stays asserted until the memory acknowledges; a repeat write is harmless.
      COMMIT: begin
        if (out_done) begin
          if (last_elem) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + IDX_SIZE'(1);
            state_d = LOAD;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      len_q   <= '0;
      op_q    <= '0;
      bias_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
      op_q    <= op_d;
      bias_q  <= bias_d;
    end
  end

  assign done           = (state_q == FIN);
  assign in_addr0       = (state_q == LOAD) ? idx_q : '0;
  assign out_write_en   = (state_q == COMMIT);
  assign out_addr0      = (state_q == COMMIT) ? idx_q : '0;
  assign out_write_data = (state_q == COMMIT) ? c_val : '0;
  assign in_clk         = clk;
  assign out_clk        = clk;

endmodule

// File: tb/tb_seq_copy_engine.sv
// tb/tb_seq_copy_engine.sv - randomized self-checking bench against an array-level reference model
module tb_seq_copy_engine;
  import seq_copy_pkg::*;

  localparam int W  = 32;
  localparam int SZ = 16;
  localparam int IW = 4;
  localparam logic [W-1:0] SENT = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic [IW:0]   len = '0;
  logic [1:0]    op = '0;
  logic [W-1:0]  bias = '0;
  logic          done;
  logic [IW-1:0] in_addr0;
  logic          in_clk;
  logic [W-1:0]  in_read_data;
  logic [IW-1:0] out_addr0;
  logic [W-1:0]  out_write_data;
  logic          out_write_en;
  logic          out_clk;
  logic          out_done = 1'b0;

  logic [W-1:0] mem_in  [SZ];
  logic [W-1:0] mem_out [SZ];
  logic [W-1:0] exp_mem [SZ];
  int           wr_cnt  [SZ];
  int           first_wr[SZ];
  int           total_wr = 0;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  seq_copy_engine #(.WIDTH(W), .SIZE(SZ), .IDX_SIZE(IW)) dut (
    .clk            (clk),
    .reset          (reset),
    .go             (go),
    .len            (len),
    .op             (op),
    .bias           (bias),
    .done           (done),
    .in_addr0       (in_addr0),
    .in_clk         (in_clk),
    .in_read_data   (in_read_data),
    .out_addr0      (out_addr0),
    .out_write_data (out_write_data),
    .out_write_en   (out_write_en),
    .out_clk        (out_clk),
    .out_done       (out_done)
  );

  always #5 clk = ~clk;

  assign in_read_data = mem_in[in_addr0];

  // Standard memory: write on the edge, done registered one cycle after write_en.
  always @(posedge out_clk) begin
    cyc      <= cyc + 1;
    out_done <= out_write_en;
    if (out_write_en) begin
      mem_out[out_addr0] <= out_write_data;
      if (wr_cnt[out_addr0] == 0) first_wr[out_addr0] <= cyc;
      wr_cnt[out_addr0] <= wr_cnt[out_addr0] + 1;
      total_wr <= total_wr + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    for (int a = 0; a < SZ; a++) begin
      wr_cnt[a]   = 0;
      first_wr[a] = -1;
      mem_out[a]  = SENT;
    end
    total_wr = 0;
  endtask

  task automatic build_model(input int n, input int n_op, input logic [W-1:0] n_bias);
    logic [W-1:0] acc;
    acc = '0;
    for (int k = 0; k < SZ; k++) begin
      exp_mem[k] = SENT;
      if (k < n) begin
        if (n_op == 1) exp_mem[k] = mem_in[k] + n_bias;
        else if (n_op == 2) begin
          acc        = acc + mem_in[k];
          exp_mem[k] = acc;
        end else exp_mem[k] = mem_in[k];
      end
    end
  endtask

  task automatic check_outputs(input string tag, input int n, input int t0);
    int distinct;
    distinct = 0;
    for (int k = 0; k < SZ; k++) begin
      if (wr_cnt[k] > 0) distinct++;
      check({tag, "_mem"}, mem_out[k], exp_mem[k]);
    end
    check({tag, "_distinct"}, distinct, n);
    check({tag, "_wr_bound"}, (total_wr >= n && total_wr <= 2 * n), 1);
    if (n > 0) begin
      check({tag, "_first_wr"}, first_wr[0], t0 + 3);
      check({tag, "_last_wr"}, first_wr[n-1], t0 + ELEM_CYCLES * (n - 1) + 3);
    end
  endtask

  task automatic run(input int n_len, input int n_op, input logic [W-1:0] n_bias, input string tag);
    int n, t0, done_cyc, pulses;
    n = (n_len > SZ) ? SZ : n_len;
    clear_logs();
    build_model(n, n_op, n_bias);
    @(negedge clk);
    go = 1'b1; len = (IW+1)'(n_len); op = 2'(n_op); bias = n_bias;
    t0 = cyc; done_cyc = -1; pulses = 0;
    for (int i = 0; i < 200 && done_cyc < 0; i++) begin
      @(negedge clk);
      if (i == 0) begin
        len = (IW+1)'($urandom); op = 2'($urandom); bias = $urandom;
      end
      if (done) begin
        pulses++; done_cyc = cyc; go = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check({tag, "_done_cyc"}, done_cyc, t0 + ELEM_CYCLES * n + 1);
    check({tag, "_pulses"}, pulses, 1);
    check_outputs(tag, n, t0);
    check({tag, "_idle_guard"}, {in_addr0, out_addr0, out_write_data, out_write_en}, '0);
  endtask

  initial begin
    int n_len, n_op, t0, d1, d2;
    bit hit;
    for (int a = 0; a < SZ; a++) mem_in[a] = '0;
    clear_logs();
    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_wen", out_write_en, 0);
    check("rst_addr", {in_addr0, out_addr0, out_write_data}, '0);
    reset = 1'b1;

    mem_in[0] = 5; mem_in[1] = 6; mem_in[2] = 7; mem_in[3] = 8;
    run(4, 0, '0, "copy");

    mem_in[0] = 1; mem_in[1] = 32'hFFFF_FFFF;
    run(2, 1, 32'd2, "bias");

    mem_in[0] = 1; mem_in[1] = 2; mem_in[2] = 3; mem_in[3] = 4;
    run(4, 2, '0, "scan");
    mem_in[0] = 1; mem_in[1] = 1;
    run(2, 2, '0, "scan2");

    run(0, 0, '0, "empty");
    for (int a = 0; a < SZ; a++) mem_in[a] = $urandom;
    run(31, 3, '0, "clamp");

    // Abort during the write of element 2.
    @(negedge clk);
    go = 1'b1; len = 5'd4; op = 2'd0;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (out_write_en && out_addr0 == 2) hit = 1;
    end
    check("rst_reach", hit, 1);
    go = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_wen", out_write_en, 0);
    check("mid_rst_done", done, 0);
    clear_logs();
    repeat (10) @(negedge clk);
    check("mid_rst_nowr", total_wr, 0);
    run(1, 0, '0, "post_rst");

    // Back-to-back: go held through done restarts on the next cycle.
    mem_in[0] = 9; mem_in[1] = 10;
    clear_logs();
    build_model(2, 0, '0);
    @(negedge clk);
    go = 1'b1; len = 5'd2; op = 2'd0; t0 = cyc; d1 = -1; d2 = -1;
    for (int i = 0; i < 200 && d2 < 0; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = cyc; else d2 = cyc;
      end
    end
    go = 1'b0;
    @(negedge clk);
    check("b2b_d1", d1, t0 + 2 * ELEM_CYCLES + 1);
    check("b2b_d2", d2, t0 + 2 * (2 * ELEM_CYCLES + 1) + 1);
    check("b2b_wr", total_wr >= 4, 1);
    check("b2b_mem0", mem_out[0], exp_mem[0]);
    check("b2b_mem1", mem_out[1], exp_mem[1]);

    for (int r = 0; r < 14; r++) begin
      for (int a = 0; a < SZ; a++) mem_in[a] = $urandom;
      n_len = $urandom_range(0, 20);
      n_op  = $urandom_range(0, 3);
      run(n_len, n_op, $urandom, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_copy_engine.md
Name: seq_copy_engine

Overview:
- Parametrised successor to the compiler-generated read→register→register→commit sequencer.
- Streams `len` elements from an input std_mem_d1-style memory to an output memory through two holding registers (b, c).
- Applies a selectable per-element op on the way.
- Exposes the standard go/done component interface so it composes under a parent tdcc-style controller.

Parameters:
WIDTH, 32, data width of memories, registers, bias and running sum
SIZE, 16, depth of both memories; maximum elements per run
IDX_SIZE, 4, address width; must satisfy 2^IDX_SIZE >= SIZE

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-low; reset==0 at a posedge resets the block
go  in  1  start request; held high by parent until done
len  in  IDX_SIZE+1  element count; sampled when run starts
op  in  2  0=copy, 1=add bias, 2=running (prefix) sum, 3=reserved (treated as copy); sampled at start
bias  in  WIDTH  addend for op 1; sampled at start
done  out  1  one-cycle completion pulse
in_addr0  out  IDX_SIZE  input memory address
in_clk  out  1  equals clk
in_read_data  in  WIDTH  combinational read data from input memory
out_addr0  out  IDX_SIZE  output memory address
out_write_data  out  WIDTH  output memory write data
out_write_en  out  1  output memory write enable
out_clk  out  1  equals clk
out_done  in  1  output memory write-done (asserts the cycle after write_en)

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; idx, b, c, sum, len_r, op_r, bias_r cleared to 0.
  - All outputs are combinational from state, so done=0, out_write_en=0, addresses=0, out_write_data=0 from that edge.
  - Reset mid-run aborts immediately; no further writes.
- States: IDLE, LOAD, XFER, COMMIT, FIN.
- IDLE, on go==1:
  - Latch len_r = min(len, SIZE), op_r, bias_r; idx=0; sum=0.
  - Next state LOAD, or FIN if len_r==0.
- LOAD (1 cycle):
  - in_addr0=idx; b <= in_read_data.
  - Next state XFER.
- XFER (1 cycle):
  - op 0/3: c <= b.
  - op 1: c <= b + bias_r.
  - op 2: c <= sum + b; sum <= sum + b.
  - All arithmetic is modulo 2^WIDTH; no saturation, no carry-out.
  - Next state COMMIT.
- COMMIT:
  - out_addr0=idx, out_write_data=c, out_write_en=1 held until out_done==1 is sampled. A duplicate write to the same address/data during that window is permitted.
  - On out_done: if idx==len_r-1 go to FIN, else idx++ and go to LOAD.
- FIN (1 cycle):
  - done=1; next state IDLE.
  - If go is still high in IDLE on the following cycle, a new run starts. The parent must drop go on the done cycle to avoid a rerun.
- Latency: with go first high in IDLE at cycle t0 and a standard memory, the write of element k is issued at t0+4k+3. done is high at t0+4·len_r+1; for len_r==0, done is high at t0+1.
- Guarded outputs:
  - in_addr0 = 0 outside LOAD.
  - out_addr0, out_write_data, out_write_en = 0 outside COMMIT.
- Changes on len/op/bias during a run are ignored.
- go low mid-run does not abort; the run completes.
- out_done outside COMMIT is ignored.

Decomposition:
- Package seq_copy_pkg:
  - state_t enum (IDLE, LOAD, XFER, COMMIT, FIN).
  - op_t enum (OP_COPY=0, OP_ADD=1, OP_SCAN=2).
  - Element period constant ELEM_CYCLES=4.
- Sub-module seq_copy_alu: combinational; inputs op, b, bias, sum; outputs c_next, sum_next. Keeps the arithmetic separately testable.
- b and c are std_reg instances; FSM and idx live in seq_copy_engine.

Test Plan:
1. Copy: memory in={5,6,7,8}, len=4, op=0, go held → out={5,6,7,8}; done single pulse at t0+17; exactly 4 distinct addresses written.
2. Bias: in={1,0xFFFFFFFF}, len=2, op=1, bias=2 → out={3,1} (wrap); done at t0+9.
3. Prefix sum: in={1,2,3,4}, len=4, op=2 → out={1,3,6,10}. A second run with in={1,1} gives out={1,2}, proving sum clears at start.
4. Empty and clamp:
   - len=0 → no out_write_en ever; done at t0+1.
   - len=31 with SIZE=16 → exactly addresses 0..15 written, then done.
5. Reset mid-run: pull reset low during COMMIT of element 2 → next cycle out_write_en=0, done=0, idle. A fresh go with len=1 then completes normally.
6. Back-to-back: keep go high through done → a second run begins the cycle after FIN. Parameter sweep WIDTH=8, SIZE=4, IDX_SIZE=2 passes scenarios 1–3.
